// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the add/sub sequencing controller: opcodes, adder op
// encodings and the controller state enum.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_ADC = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_SBC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic [1:0] {
    EN_ADD = 2'b00,
    EN_ADC = 2'b01,
    EN_SUB = 2'b10,
    EN_SBC = 2'b11
  } addsub_en_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_SETUP,
    S_STEP,
    S_DONE
  } state_e;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: overflow-corrected arithmetic right shift of
// {acc, q, q_1} after the adder has summed acc with the selected addend.
module booth_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             a_neg,
  input  logic             b_neg,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic ovf;

  // b_neg is the true sign of the addend, which differs from its MSB only
  // when the addend is -M for the most negative M (i.e. +2^(W-1)).
  assign ovf = (a_neg == b_neg) && (add_sum[WIDTH-1] != a_neg);

  assign {acc_next, q_next, q_1_next} = {add_sum[WIDTH-1] ^ ovf, add_sum, q};

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencing controller for the shared add/sub unit: single-cycle add/sub
// family and a W-step radix-2 Booth signed multiply on the external adder.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_flag,
  output logic               err,
  output logic               mux_addsub_mult_op,
  output logic [1:0]         addsub_unit_en,
  output logic               op_mult_in,
  output logic               cin,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   neg_m_q, neg_m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q_1_q, q_1_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               err_q, err_d;

  addsub_en_e         en_sel;
  logic               b_neg;
  logic [WIDTH-1:0]   acc_nx, q_nx;
  logic               q_1_nx;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .q        (q_q),
    .add_sum  (add_sum),
    .a_neg    (acc_q[WIDTH-1]),
    .b_neg    (b_neg),
    .acc_next (acc_nx),
    .q_next   (q_nx),
    .q_1_next (q_1_nx)
  );

  // Adder operand and op-select drive, purely a function of the current state.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    mux_addsub_mult_op = 1'b0;
    en_sel             = EN_ADD;
    add_a              = '0;
    add_b              = '0;
    b_neg              = 1'b0;
    unique case (state_q)
      S_EXEC: begin
        en_sel = addsub_en_e'(op_q[1:0]);
        add_a  = a_q;
        add_b  = b_q;
      end
      S_SETUP: begin
        en_sel = EN_SUB;
        add_b  = a_q;
      end
      S_STEP: begin
        mux_addsub_mult_op = 1'b1;
        add_a              = acc_q;
        unique case ({q_q[0], q_1_q})
          2'b01: begin
            add_b = a_q;
            b_neg = a_q[WIDTH-1];
          end
          2'b10: begin
            add_b = neg_m_q;
            b_neg = ~a_q[WIDTH-1] & (|a_q);
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    neg_m_d  = neg_m_q;
    acc_d    = acc_q;
    q_d      = q_q;
    q_1_d    = q_1_q;
    count_d  = count_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = opcode;
          a_d  = a;
          b_d  = b;
          if (!opcode[2]) begin
            state_d = S_EXEC;
          end else if (opcode == OP_MUL) begin
            state_d = S_SETUP;
          end else begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_EXEC: begin
        result_d = {{WIDTH{1'b0}}, add_sum};
        carry_d  = op_q[1] ? ~add_cout : add_cout;
        err_d    = 1'b0;
        state_d  = S_DONE;
      end
      S_SETUP: begin
        neg_m_d = add_sum;
        acc_d   = '0;
        q_d     = b_q;
        q_1_d   = 1'b0;
        count_d = '0;
        state_d = S_STEP;
      end
      S_STEP: begin
        acc_d   = acc_nx;
        q_d     = q_nx;
        q_1_d   = q_1_nx;
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          result_d = {acc_nx, q_nx};
          err_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments; reset is synchronous.
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      neg_m_q  <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      q_1_q    <= 1'b0;
      count_q  <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      neg_m_q  <= neg_m_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      q_1_q    <= q_1_d;
      count_q  <= count_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign result         = result_q;
  assign carry_flag     = carry_q;
  assign err            = err_q;
  assign cin            = carry_q;
  assign op_mult_in     = 1'b0;
  assign addsub_unit_en = en_sel;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: models the external adder and op mux,
// and predicts results from plain arithmetic on the commanded operands.
module tb_alu_seq_ctrl;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2:0]     opcode;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] result;
  logic           carry_flag, err;
  logic           mux_addsub_mult_op;
  logic [1:0]     addsub_unit_en;
  logic           op_mult_in, cin;
  logic [W-1:0]   add_a, add_b, add_sum;
  logic           add_cout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2*W-1:0] exp_result = '0;
  logic           exp_cf     = 1'b0;
  logic           exp_err    = 1'b0;

  alu_seq_ctrl #(.WIDTH(W)) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .opcode             (opcode),
    .a                  (a),
    .b                  (b),
    .busy               (busy),
    .done               (done),
    .result             (result),
    .carry_flag         (carry_flag),
    .err                (err),
    .mux_addsub_mult_op (mux_addsub_mult_op),
    .addsub_unit_en     (addsub_unit_en),
    .op_mult_in         (op_mult_in),
    .cin                (cin),
    .add_a              (add_a),
    .add_b              (add_b),
    .add_sum            (add_sum),
    .add_cout           (add_cout)
  );

  always #5 clk = ~clk;

  // External adder behind the op mux: 00 add, 01 add+cin, 10 sub, 11 sub with
  // borrow (carry-in = ~borrow); multiply-step mode uses op_mult_in, carry-in 0.
  logic       tb_op, tb_ci;
  logic [W:0] tb_t;
  always_comb begin
    tb_op = 1'b0;
    tb_ci = 1'b0;
    if (mux_addsub_mult_op) begin
      tb_op = op_mult_in;
    end else begin
      tb_op = addsub_unit_en[1];
      tb_ci = addsub_unit_en[0] ? (addsub_unit_en[1] ? ~cin : cin) : addsub_unit_en[1];
    end
    tb_t     = {1'b0, add_a} + {1'b0, (tb_op ? ~add_b : add_b)} + {{W{1'b0}}, tb_ci};
    add_sum  = tb_t[W-1:0];
    add_cout = tb_t[W];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected architectural state after a command, from plain arithmetic.
  task automatic model(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    longint xi, yi, s;
    xi = longint'(x);
    yi = longint'(y);
    case (op)
      3'd0, 3'd1: begin
        s          = xi + yi + ((op == 3'd1) ? longint'(exp_cf) : 0);
        exp_result = {{W{1'b0}}, s[W-1:0]};
        exp_cf     = s[W];
        exp_err    = 1'b0;
      end
      3'd2, 3'd3: begin
        s          = xi - yi - ((op == 3'd3) ? longint'(exp_cf) : 0);
        exp_result = {{W{1'b0}}, s[W-1:0]};
        exp_cf     = (s < 0);
        exp_err    = 1'b0;
      end
      3'd4: begin
        s          = longint'($signed(x)) * longint'($signed(y));
        exp_result = s[2*W-1:0];
        exp_err    = 1'b0;
      end
      default: exp_err = 1'b1;
    endcase
  endtask

  // Addend expected in Booth step i: pair {y[i], y[i-1]}, y[-1] = 0.
  function automatic logic [W-1:0] booth_b(input logic [W-1:0] m, input logic [W-1:0] y, input int i);
    logic [1:0] pr;
    pr[1] = y[i];
    pr[0] = (i == 0) ? 1'b0 : y[(i == 0) ? 0 : i - 1];
    case (pr)
      2'b01:   return m;
      2'b10:   return W'(0) - m;
      default: return '0;
    endcase
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input int poke_at);
    int n, steps, exp_lat;
    bit seen;
    exp_lat = (op == 3'd4) ? W + 2 : (op[2] ? 1 : 2);
    @(negedge clk);
    start = 1'b1; opcode = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    model(op, x, y);
    n = 1; steps = 0; seen = 1'b0;
    while (n <= 60) begin
      if (mux_addsub_mult_op) begin
        check("step_op_mult_in", op_mult_in, 0);
        if (steps < W) check("step_add_b", add_b, booth_b(x, y, steps));
        steps++;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (n == poke_at) begin
        start = 1'b1; opcode = 3'd0; a = 16'h1234; b = 16'h4321;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_seen", seen, 1);
    check("latency", n, exp_lat);
    check("result", result, exp_result);
    check("carry_flag", carry_flag, exp_cf);
    check("err", err, exp_err);
    if (op == 3'd4) check("mul_step_count", steps, W);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_carry"}, carry_flag, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_ctrl"}, {mux_addsub_mult_op, addsub_unit_en, op_mult_in, cin}, 0);
    check({tag, "_add_ab"}, {add_a, add_b}, 0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'hFFFF;
      default: return W'($urandom());
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rop;
    rst = 1'b1; start = 1'b0; opcode = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_cmd(3'd0, 16'hFFFF, 16'h0001, 0);
    check("plan_add", {result, carry_flag}, {32'h0000_0000, 1'b1});
    run_cmd(3'd1, 16'h0000, 16'h0000, 0);
    check("plan_adc", {result, carry_flag}, {32'h0000_0001, 1'b0});
    run_cmd(3'd2, 16'd3, 16'd5, 0);
    check("plan_sub", {result[W-1:0], carry_flag}, {16'hFFFE, 1'b1});
    run_cmd(3'd3, 16'd5, 16'd3, 0);
    check("plan_sbc", {result[W-1:0], carry_flag}, {16'h0001, 1'b0});

    run_cmd(3'd4, 16'd7, 16'hFFFD, 0);
    check("plan_mul_7_m3", result, 32'hFFFF_FFEB);
    run_cmd(3'd4, 16'h8000, 16'h8000, 0);
    check("plan_mul_min_min", result, 32'h4000_0000);
    run_cmd(3'd4, 16'h7FFF, 16'h7FFF, 0);
    check("plan_mul_max_max", result, 32'h3FFF_0001);

    run_cmd(3'd5, 16'hAAAA, 16'h5555, 0);
    check("plan_illegal_keeps_result", result, 32'h3FFF_0001);
    run_cmd(3'd0, 16'd1, 16'd2, 0);

    // start pulsed mid-multiply must be dropped
    run_cmd(3'd4, 16'h0123, 16'hF00F, 5);

    // Reset in the middle of the Booth sequence
    @(negedge clk);
    start = 1'b1; opcode = 3'd4; a = 16'h1111; b = 16'h2222;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("in_step_before_rst", mux_addsub_mult_op, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("mid_rst");
    rst = 1'b0;
    exp_result = '0; exp_cf = 1'b0; exp_err = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("no_done_after_rst", {done, busy}, 0);
    end

    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      run_cmd(rop, pick_operand(), pick_operand(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
